// File: rtl/tlul_socket_m1n.sv
// -----------------------------------------------------------------------------
// tlul_socket_m1n
//
// TL-UL 1:N steering socket. One host port fans out to NumDev device ports.
// An external decoder supplies the target index for every request. TL-UL
// response ordering is preserved by allowing in-flight requests to only one
// target at a time. A switch to a different target stalls until every
// outstanding response has drained.
//
// Optional feature (compile-time macro TLUL_SOCKET_M1N_ERR_EN):
//   defined     - dev_select_i >= NumDev routes to an internal error responder
//                 at target index NumDev. The responder answers every request
//                 with d_error=1. It returns AccessAckData with all-ones data
//                 for a Get, and AccessAck for any other request.
//   not defined - dev_select_i >= NumDev is saturated to NumDev-1. An
//                 assertion flags an out-of-range select that comes with a
//                 request.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   tl_h_i        host request channel A, plus host d_ready
//   tl_h_o        host response channel D, plus a_ready
//   dev_select_i  target index for tl_h_i.a_address (NumDev = no device)
//   tl_d_o[N]     per-device request
//   tl_d_i[N]     per-device response
//   outstd_o      current in-flight request count (debug)
//
// Handshake semantics (both channels, every port): a beat transfers on the
// rising clock edge where valid and ready are both high. A source holds valid
// and its payload stable until that edge. valid never waits on ready.
// -----------------------------------------------------------------------------

package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_socket_m1n
    import tlul_pkg::*;
#(
    parameter  int NumDev    = 4,
    parameter  int MaxOutstd = 8,
    localparam int SelW      = $clog2(NumDev + 1),
    localparam int CntW      = $clog2(MaxOutstd + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_h2d_t         tl_h_i,
    output tl_d2h_t         tl_h_o,
    input  logic [SelW-1:0] dev_select_i,
    output tl_h2d_t         tl_d_o [NumDev],
    input  tl_d2h_t         tl_d_i [NumDev],
    output logic [CntW-1:0] outstd_o
);

`ifdef TLUL_SOCKET_M1N_ERR_EN
    localparam int NumTgt = NumDev + 1;
`else
    localparam int NumTgt = NumDev;
`endif

    logic [CntW-1:0] cnt_q;
    logic [SelW-1:0] sel_q;

    logic [SelW-1:0] sel_eff;
    tl_d2h_t         rsp [NumTgt];
    tl_d2h_t         rsp_sel;
    logic            tgt_a_ready;
    logic            d_valid_h;
    logic            d_acc;
    logic            a_acc;
    logic [CntW-1:0] cnt_base;
    logic            hold;

    // Clamp an out-of-range select to a real target index.
    always_comb begin
        sel_eff = dev_select_i;
        if (int'(dev_select_i) >= NumDev) begin
`ifdef TLUL_SOCKET_M1N_ERR_EN
            sel_eff = SelW'(NumDev);
`else
            sel_eff = SelW'(NumDev - 1);
`endif
        end
    end

    for (genvar g = 0; g < NumDev; g++) begin : g_rsp
        assign rsp[g] = tl_d_i[g];
    end

    always_comb begin
        rsp_sel     = '0;
        tgt_a_ready = 1'b0;
        for (int i = 0; i < NumTgt; i++) begin
            if (sel_q == SelW'(i)) rsp_sel = rsp[i];
            if (sel_eff == SelW'(i)) tgt_a_ready = rsp[i].a_ready;
        end
    end

    // A response only counts while something is in flight. This drops stray
    // responses that arrive after a reset.
    assign d_valid_h = rsp_sel.d_valid && (cnt_q != '0);
    assign d_acc     = d_valid_h && tl_h_i.d_ready;

    // The stall decision uses the count as it will be after this cycle's
    // response retires. This lets a target switch happen in the same cycle as
    // the last drain. It also lets a full socket take a new request while one
    // response retires. The count therefore never exceeds MaxOutstd.
    assign cnt_base = cnt_q - CntW'(d_acc);
    assign hold     = ((cnt_base != '0) && (sel_eff != sel_q))
                   || (cnt_base == CntW'(MaxOutstd));

    assign a_acc = tl_h_i.a_valid && tl_h_o.a_ready;

    always_comb begin
        tl_h_o         = rsp_sel;
        tl_h_o.d_valid = d_valid_h;
        tl_h_o.a_ready = rst_ni && !hold && tgt_a_ready;
    end

    always_comb begin
        for (int i = 0; i < NumDev; i++) begin
            tl_d_o[i]         = tl_h_i;
            tl_d_o[i].a_valid = rst_ni && tl_h_i.a_valid && !hold
                             && (sel_eff == SelW'(i));
            tl_d_o[i].d_ready = tl_h_i.d_ready && (sel_q == SelW'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            if (a_acc) sel_q <= sel_eff;
            if (a_acc && !d_acc) cnt_q <= cnt_q + CntW'(1);
            else if (d_acc && !a_acc) cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign outstd_o = cnt_q;

`ifdef TLUL_SOCKET_M1N_ERR_EN
    // Error responder: a single-entry buffer. Its response is visible the
    // cycle after the request is accepted, and it holds until the host takes
    // it.
    logic       err_busy_q;
    logic       err_get_q;
    logic [1:0] err_size_q;
    logic [7:0] err_source_q;
    logic       err_a_acc;
    logic       err_d_ready;
    tl_d2h_t    err_rsp;

    assign err_a_acc   = a_acc && (sel_eff == SelW'(NumDev));
    assign err_d_ready = tl_h_i.d_ready && (sel_q == SelW'(NumDev));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_busy_q   <= 1'b0;
            err_get_q    <= 1'b0;
            err_size_q   <= '0;
            err_source_q <= '0;
        end else if (err_a_acc) begin
            err_busy_q   <= 1'b1;
            err_get_q    <= (tl_h_i.a_opcode == Get);
            err_size_q   <= tl_h_i.a_size;
            err_source_q <= tl_h_i.a_source;
        end else if (err_busy_q && err_d_ready) begin
            err_busy_q <= 1'b0;
        end
    end

    always_comb begin
        err_rsp          = '0;
        err_rsp.d_valid  = err_busy_q;
        err_rsp.d_opcode = err_get_q ? AccessAckData : AccessAck;
        err_rsp.d_size   = err_size_q;
        err_rsp.d_source = err_source_q;
        err_rsp.d_data   = err_get_q ? 32'hFFFF_FFFF : 32'h0;
        err_rsp.d_error  = 1'b1;
        err_rsp.a_ready  = !err_busy_q;
    end

    assign rsp[NumDev] = err_rsp;
`else
    sel_in_range_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        tl_h_i.a_valid |-> (int'(dev_select_i) < NumDev));
`endif

endmodule

// File: tb/tb_tlul_socket_m1n.sv
module tb_tlul_socket_m1n;
    import tlul_pkg::*;

    localparam int NumDev    = 4;
    localparam int MaxOutstd = 8;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    tl_h2d_t     tl_h_i;
    tl_d2h_t     tl_h_o;
    logic [2:0]  dev_select_i;
    tl_h2d_t     tl_d_o [NumDev];
    tl_d2h_t     tl_d_i [NumDev];
    logic [3:0]  outstd_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];

    tlul_socket_m1n #(
        .NumDev    (NumDev),
        .MaxOutstd (MaxOutstd)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .tl_h_i       (tl_h_i),
        .tl_h_o       (tl_h_o),
        .dev_select_i (dev_select_i),
        .tl_d_o       (tl_d_o),
        .tl_d_i       (tl_d_i),
        .outstd_o     (outstd_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        tl_h_i       = '0;
        dev_select_i = '0;
        for (int i = 0; i < NumDev; i++) begin
            tl_d_i[i]         = '0;
            tl_d_i[i].a_ready = 1'b1;
        end
    endtask

    task automatic host_a(input logic [2:0] sel, input logic [2:0] op, input logic [7:0] src);
        tl_h_i.a_valid   = 1'b1;
        tl_h_i.a_opcode  = op;
        tl_h_i.a_source  = src;
        tl_h_i.a_size    = 2'd2;
        tl_h_i.a_mask    = 4'hF;
        tl_h_i.a_address = {1'b0, sel, 28'h0};
        dev_select_i     = sel;
    endtask

    task automatic dev_d(input int dev, input logic valid, input logic [7:0] src);
        tl_d_i[dev].d_valid  = valid;
        tl_d_i[dev].d_source = src;
        tl_d_i[dev].d_opcode = AccessAckData;
        tl_d_i[dev].d_size   = 2'd2;
        tl_d_i[dev].d_data   = {24'hD00000, src};
    endtask

    initial begin
        // Reset state, with a request already presented
        idle_all();
        host_a(3'd0, Get, 8'h01);
        repeat (2) @(negedge clk_i);
        check_eq("rst_outstd", outstd_o, 4'd0);
        check_eq("rst_d_valid", tl_h_o.d_valid, 1'b0);
        check_eq("rst_dev0_a_valid", tl_d_o[0].a_valid, 1'b0);
        #1 rst_ni = 1'b1;
        idle_all();
        tick();

        // Four Gets to dev 2, then four in-order D beats
        for (int k = 0; k < 4; k++) begin
            host_a(3'd2, Get, 8'h10 + 8'(k));
            @(negedge clk_i);
            check_eq("t2_a_ready", tl_h_o.a_ready, 1'b1);
            check_eq("t2_dev2_a_valid", tl_d_o[2].a_valid, 1'b1);
            check_eq("t2_dev0_a_valid", tl_d_o[0].a_valid, 1'b0);
            check_eq("t2_outstd_rise", outstd_o, 4'(k));
            exp_q.push_back(8'h10 + 8'(k));
            tick();
        end
        tl_h_i.a_valid = 1'b0;
        @(negedge clk_i);
        check_eq("t2_outstd4", outstd_o, 4'd4);
        tick();
        tl_h_i.d_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dev_d(2, 1'b1, 8'h10 + 8'(k));
            @(negedge clk_i);
            check_eq("t2_d_valid", tl_h_o.d_valid, 1'b1);
            check_eq("t2_d_source", tl_h_o.d_source, exp_q.pop_front());
            check_eq("t2_dev2_d_ready", tl_d_o[2].d_ready, 1'b1);
            check_eq("t2_dev1_d_ready", tl_d_o[1].d_ready, 1'b0);
            tick();
        end
        dev_d(2, 1'b0, 8'h0);
        tl_h_i.d_ready = 1'b0;
        @(negedge clk_i);
        check_eq("t2_outstd0", outstd_o, 4'd0);
        check_eq("t2_d_valid_idle", tl_h_o.d_valid, 1'b0);
        tick();

        // Target switch stalls, then proceeds in the cycle the last D retires
        idle_all();
        host_a(3'd0, Get, 8'h20);
        @(negedge clk_i);
        check_eq("t3_dev0_a_ready", tl_h_o.a_ready, 1'b1);
        tick();
        host_a(3'd1, PutFullData, 8'h21);
        @(negedge clk_i);
        check_eq("t3_stall_a_ready", tl_h_o.a_ready, 1'b0);
        check_eq("t3_stall_dev1_a_valid", tl_d_o[1].a_valid, 1'b0);
        check_eq("t3_stall_outstd", outstd_o, 4'd1);
        tick();
        dev_d(0, 1'b1, 8'h20);
        tl_h_i.d_ready = 1'b1;
        @(negedge clk_i);
        check_eq("t3_switch_a_ready", tl_h_o.a_ready, 1'b1);
        check_eq("t3_switch_dev1_a_valid", tl_d_o[1].a_valid, 1'b1);
        check_eq("t3_dev0_d_source", tl_h_o.d_source, 8'h20);
        tick();
        tl_h_i.a_valid = 1'b0;
        dev_d(0, 1'b0, 8'h0);
        dev_d(1, 1'b1, 8'h21);
        @(negedge clk_i);
        check_eq("t3_outstd_after_switch", outstd_o, 4'd1);
        check_eq("t3_dev1_d_source", tl_h_o.d_source, 8'h21);
        check_eq("t3_dev1_d_ready", tl_d_o[1].d_ready, 1'b1);
        check_eq("t3_dev0_d_ready", tl_d_o[0].d_ready, 1'b0);
        tick();
        dev_d(1, 1'b0, 8'h0);
        tl_h_i.d_ready = 1'b0;
        @(negedge clk_i);
        check_eq("t3_outstd0", outstd_o, 4'd0);
        tick();

        // MaxOutstd requests to dev 3; ninth held; A+D at full keeps cnt=8
        idle_all();
        for (int k = 0; k < MaxOutstd; k++) begin
            host_a(3'd3, Get, 8'h30 + 8'(k));
            tick();
        end
        host_a(3'd3, Get, 8'h38);
        @(negedge clk_i);
        check_eq("t4_outstd_full", outstd_o, 4'd8);
        check_eq("t4_ninth_a_ready", tl_h_o.a_ready, 1'b0);
        check_eq("t4_ninth_dev3_a_valid", tl_d_o[3].a_valid, 1'b0);
        tick();
        dev_d(3, 1'b1, 8'h30);
        tl_h_i.d_ready = 1'b1;
        @(negedge clk_i);
        check_eq("t4_full_ad_a_ready", tl_h_o.a_ready, 1'b1);
        check_eq("t4_full_ad_dev3_a_valid", tl_d_o[3].a_valid, 1'b1);
        tick();
        tl_h_i.a_valid = 1'b0;
        @(negedge clk_i);
        check_eq("t4_outstd_still_full", outstd_o, 4'd8);
        tick();
        for (int k = 0; k < 20 && outstd_o != 4'd0; k++) tick();
        check_eq("t4_drain_outstd", outstd_o, 4'd0);

        // Simultaneous A and D on dev 1 at cnt=3
        idle_all();
        for (int k = 0; k < 3; k++) begin
            host_a(3'd1, Get, 8'h60 + 8'(k));
            tick();
        end
        host_a(3'd1, Get, 8'h63);
        dev_d(1, 1'b1, 8'h60);
        tl_h_i.d_ready = 1'b1;
        @(negedge clk_i);
        check_eq("t6_outstd3", outstd_o, 4'd3);
        check_eq("t6_a_ready", tl_h_o.a_ready, 1'b1);
        check_eq("t6_d_valid", tl_h_o.d_valid, 1'b1);
        tick();
        tl_h_i.a_valid = 1'b0;
        tl_h_i.d_ready = 1'b0;
        dev_d(1, 1'b1, 8'h61);
        @(negedge clk_i);
        check_eq("t6_outstd_stays3", outstd_o, 4'd3);
        check_eq("t6_route_dev1_source", tl_h_o.d_source, 8'h61);
        check_eq("t6_route_dev1_valid", tl_h_o.d_valid, 1'b1);

        // Asynchronous reset mid-traffic, away from the clock edge
        host_a(3'd1, Get, 8'h64);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("t1_midrst_outstd", outstd_o, 4'd0);
        check_eq("t1_midrst_d_valid", tl_h_o.d_valid, 1'b0);
        check_eq("t1_midrst_dev1_a_valid", tl_d_o[1].a_valid, 1'b0);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        idle_all();
        tick();
        @(negedge clk_i);
        check_eq("t1_post_rst_outstd", outstd_o, 4'd0);
        tick();

`ifdef TLUL_SOCKET_M1N_ERR_EN
        // Error responder
        idle_all();
        host_a(3'd4, Get, 8'h05);
        @(negedge clk_i);
        check_eq("t5_err_a_ready", tl_h_o.a_ready, 1'b1);
        check_eq("t5_err_no_dev_a_valid", tl_d_o[3].a_valid, 1'b0);
        tick();
        tl_h_i.a_valid = 1'b0;
        @(negedge clk_i);
        check_eq("t5_d_valid", tl_h_o.d_valid, 1'b1);
        check_eq("t5_d_error", tl_h_o.d_error, 1'b1);
        check_eq("t5_d_source", tl_h_o.d_source, 8'h05);
        check_eq("t5_d_size", tl_h_o.d_size, 2'd2);
        check_eq("t5_d_opcode", tl_h_o.d_opcode, AccessAckData);
        check_eq("t5_d_data", tl_h_o.d_data, 32'hFFFF_FFFF);
        check_eq("t5_outstd1", outstd_o, 4'd1);
        tick();
        host_a(3'd4, PutFullData, 8'h06);
        @(negedge clk_i);
        check_eq("t5_busy_a_ready", tl_h_o.a_ready, 1'b0);
        tick();
        tl_h_i.d_ready = 1'b1;
        tick();
        @(negedge clk_i);
        check_eq("t5_retired_outstd", outstd_o, 4'd0);
        check_eq("t5_free_a_ready", tl_h_o.a_ready, 1'b1);
        tick();
        tl_h_i.a_valid = 1'b0;
        @(negedge clk_i);
        check_eq("t5_put_opcode", tl_h_o.d_opcode, AccessAck);
        check_eq("t5_put_source", tl_h_o.d_source, 8'h06);
        check_eq("t5_put_error", tl_h_o.d_error, 1'b1);
        tick();
        @(negedge clk_i);
        check_eq("t5_put_retired", outstd_o, 4'd0);
        tick();
`else
        // Out-of-range select saturates to the last device (no request presented)
        idle_all();
        dev_select_i      = 3'd4;
        tl_d_i[3].a_ready = 1'b0;
        @(negedge clk_i);
        check_eq("sat_a_ready_low", tl_h_o.a_ready, 1'b0);
        tl_d_i[3].a_ready = 1'b1;
        #1;
        check_eq("sat_a_ready_high", tl_h_o.a_ready, 1'b1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
